// File: rtl/cost_pkg.sv
// Shared definitions for the epoch-level cost controller: FSM encoding,
// default word geometry and the fixed-point ONE constant.
package cost_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    EVAL   = 3'd3,
    REPORT = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 24;

  // 1.0 in the default fixed-point format.
  localparam int ONE = 1 << DEF_FRAC;

endpackage

// File: rtl/cost_epoch_ctrl_if.sv
// Signal bundle between the cost epoch controller, the external accumulator
// and the host. Optional best-epoch ports exist only with COST_BEST_TRACK_EN.
interface cost_epoch_ctrl_if import cost_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EPW   = 16
);

  logic                    start;
  logic signed [WIDTH-1:0] i_thr;
  logic                    i_smp_valid;
  logic                    o_smp_ready;
  logic                    o_acc_en;
  logic                    o_acc_clr;
  logic signed [WIDTH-1:0] i_cost;
  logic signed [WIDTH-1:0] o_mean;
  logic [EPW-1:0]          o_epoch;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_conv;
  logic                    o_done;
  logic                    o_busy;
  state_t                  dbg_state;
`ifdef COST_BEST_TRACK_EN
  logic signed [WIDTH-1:0] o_best;
  logic [EPW-1:0]          o_best_epoch;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high (i_smp_valid/o_smp_ready for samples, o_valid/i_ready for
  // reports); a raised valid and its payload stay stable until that edge.

  modport slave (
    input  start, i_thr, i_smp_valid, i_cost, i_ready,
    output o_smp_ready, o_acc_en, o_acc_clr, o_mean, o_epoch, o_valid,
           o_conv, o_done, o_busy, dbg_state
`ifdef COST_BEST_TRACK_EN
    , output o_best, o_best_epoch
`endif
  );

  modport master (
    output start, i_thr, i_smp_valid, i_cost, i_ready,
    input  o_smp_ready, o_acc_en, o_acc_clr, o_mean, o_epoch, o_valid,
           o_conv, o_done, o_busy, dbg_state
`ifdef COST_BEST_TRACK_EN
    , input o_best, o_best_epoch
`endif
  );

endinterface

// File: rtl/cost_epoch_ctrl.sv
// Epoch controller for the squared-error cost accumulator: clears it per epoch,
// averages its result, reports to the host, stops on convergence or epoch limit.
// Optional best-epoch tracking is enabled by defining COST_BEST_TRACK_EN.
module cost_epoch_ctrl
  import cost_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC      = DEF_FRAC,
  parameter int LOG2_N    = 4,
  parameter int EPW       = 16,
  parameter int MAX_EPOCH = 1000
) (
  input logic              clk,
  input logic              rst,
  cost_epoch_ctrl_if.slave bus
);

  if (FRAC >= WIDTH || MAX_EPOCH < 1 || MAX_EPOCH > (2**EPW) - 1 || LOG2_N < 1) begin : g_param_check
    $error("cost_epoch_ctrl: illegal parameter combination");
  end

  state_t                  state_q, state_d;
  logic [LOG2_N-1:0]       cnt_q;
  logic signed [WIDTH-1:0] thr_q;
  logic signed [WIDTH-1:0] mean_q;
  logic [EPW-1:0]          epoch_q;
  logic                    conv_q;
  logic                    start_ok;
  logic                    smp_ready;
  logic                    acc_en;
  logic signed [WIDTH-1:0] mean_next;

  // Arithmetic shift on the signed accumulator output rounds toward -inf.
  assign mean_next = bus.i_cost >>> LOG2_N;
  assign acc_en    = bus.i_smp_valid & smp_ready;

  always_comb begin
    state_d       = state_q;
    start_ok      = 1'b0;
    smp_ready     = 1'b0;
    bus.o_acc_clr = 1'b0;
    bus.o_valid   = 1'b0;
    bus.o_done    = 1'b0;
    bus.o_busy    = 1'b1;
    case (state_q)
      IDLE: begin
        bus.o_busy = 1'b0;
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = CLR;
        end
      end
      CLR: begin
        bus.o_acc_clr = 1'b1;
        state_d       = RUN;
      end
      RUN: begin
        smp_ready = 1'b1;
        if (bus.i_smp_valid && cnt_q == '1) state_d = EVAL;
      end
      EVAL: state_d = REPORT;
      REPORT: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) begin
          state_d = (conv_q || epoch_q == EPW'(MAX_EPOCH)) ? DONE : CLR;
        end
      end
      DONE: begin
        bus.o_busy = 1'b0;
        bus.o_done = 1'b1;
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = CLR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      thr_q   <= '0;
      mean_q  <= '0;
      epoch_q <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        thr_q   <= bus.i_thr;
        epoch_q <= '0;
        conv_q  <= 1'b0;
      end
      if (state_q == CLR) begin
        cnt_q <= '0;
      end else if (acc_en) begin
        cnt_q <= cnt_q + LOG2_N'(1);
      end
      if (state_q == EVAL) begin
        mean_q  <= mean_next;
        conv_q  <= mean_next < thr_q;
        epoch_q <= epoch_q + EPW'(1);
      end
    end
  end

`ifdef COST_BEST_TRACK_EN
  logic signed [WIDTH-1:0] best_q;
  logic [EPW-1:0]          best_epoch_q;

  // Strict less-than keeps the earlier epoch on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q       <= '0;
      best_epoch_q <= '0;
    end else if (start_ok) begin
      best_q       <= '0;
      best_epoch_q <= '0;
    end else if (state_q == EVAL && (epoch_q == '0 || mean_next < best_q)) begin
      best_q       <= mean_next;
      best_epoch_q <= epoch_q + EPW'(1);
    end
  end

  assign bus.o_best       = best_q;
  assign bus.o_best_epoch = best_epoch_q;
`endif

  assign bus.o_smp_ready = smp_ready;
  assign bus.o_acc_en    = acc_en;
  assign bus.o_mean      = mean_q;
  assign bus.o_epoch     = epoch_q;
  assign bus.o_conv      = conv_q;
  assign bus.dbg_state   = state_q;

endmodule
